dmac_iochannel_mc: RTL
======================

DMAC_IOCHANNEL_MC -- requirements
Module: dmac_iochannel_mc

Interface
REQ-001 Parameters (name, default, meaning), SHALL be: W_D 32 data width; W_EXT_A 32 byte address width; W_BLEN 8 burst-length width; NUM_CH 4 channel count (power of 2, >=2); W_CH log2(NUM_CH); CH_LSB 12 lowest address bit of channel index; FIFO_ADDR_WIDTH 4 log2 of per-channel FIFO depth.
REQ-002 Clock and reset SHALL be: ACLK in 1 sole clock; ARESETN in 1 reset, asynchronous, active-low.
REQ-003 Write channel ports SHALL be: awvalid in 1; awaddr in W_EXT_A; awlen in W_BLEN; awready out 1; wvalid in 1; wdata in W_D; wlast in 1; wready out 1; bvalid out 1; bresp out 2; bready in 1.
REQ-004 Read channel ports SHALL be: arvalid in 1; araddr in W_EXT_A; arlen in W_BLEN; arready out 1; rvalid out 1; rdata out W_D; rresp out 2; rlast out 1; rready in 1.
REQ-005 User-side ports SHALL be: coram_deq in NUM_CH; coram_q out NUM_CH*W_D; coram_empty out NUM_CH; coram_almost_empty out NUM_CH; coram_enq in NUM_CH; coram_d in NUM_CH*W_D; coram_full out NUM_CH; coram_almost_full out NUM_CH. Bit/slice i belongs to channel i.

Function
REQ-006 Channel index SHALL be addr[CH_LSB +: W_CH]; a channel bit above W_CH-1 is not decoded. Address bits W_CH+CH_LSB and above that are nonzero SHALL mark the transaction DECERR (bresp/rresp 2'b11).
REQ-007 Each channel SHALL own a write FIFO (bus->user) and a read FIFO (user->bus).
REQ-008 The FSM SHALL use states IDLE, WDATA, WRESP, RDATA, with one transaction outstanding.
REQ-009 awready SHALL be 1 iff state==IDLE; arready SHALL be 1 iff state==IDLE && !awvalid. Write has fixed priority over read.
REQ-010 AW handshake SHALL latch the channel, the DECERR flag and beat count awlen+1 (W_BLEN+1 bits; awlen=255 gives 256 beats), then go IDLE->WDATA.
REQ-011 wready SHALL be (state==WDATA) && (DECERR || !full[ch]). A beat SHALL enqueue wdata to write FIFO ch unless DECERR; under DECERR it is discarded.
REQ-012 On the beat where the remaining count reaches 0, the FSM SHALL go WDATA->WRESP. A wlast mismatch (asserted early or absent on the final beat) SHALL set bresp=2'b10 SLVERR unless DECERR. Otherwise bresp SHALL be 2'b00.
REQ-013 bvalid SHALL be 1 iff state==WRESP. bvalid&&bready SHALL return the FSM to IDLE. bresp SHALL be stable while bvalid is high.
REQ-014 AR handshake SHALL latch the channel, the DECERR flag and count arlen+1, then go IDLE->RDATA.
REQ-015 In RDATA, rvalid SHALL be DECERR || !empty[ch]. rdata SHALL be the FWFT head of read FIFO ch, or 0 under DECERR. rresp SHALL be 2'b00 or 2'b11. rlast SHALL be 1 iff remaining==1.
REQ-016 rvalid&&rready SHALL dequeue read FIFO ch (no dequeue under DECERR). The final beat SHALL go RDATA->IDLE.
REQ-017 All outputs other than rdata/rresp SHALL be driven 0 outside their state. Once asserted, rvalid/rdata SHALL hold until rready.

FIFO behaviour
REQ-018 Each FIFO SHALL be synchronous and first-word-fall-through, with depth 2**FIFO_ADDR_WIDTH and a full-depth usable occupancy counter.
REQ-019 enq when full SHALL be ignored, even with a simultaneous deq. deq when empty SHALL be ignored, even with a simultaneous enq. Simultaneous enq+deq otherwise SHALL leave the count unchanged.
REQ-020 Flags SHALL be registered from the count: empty=count==0; almost_empty=count<=1; full=count==DEPTH; almost_full=count>=DEPTH-1. Pointers SHALL wrap modulo DEPTH.

Reset
REQ-021 ARESETN low SHALL asynchronously force: state IDLE, all counts and pointers 0, awready/wready/bvalid/arready/rvalid/rlast 0, bresp/rresp 0, rdata 0, empty/almost_empty 1, full/almost_full 0. Deassertion SHALL be synchronised by a 2-flop synchroniser.
REQ-022 Reset mid-burst SHALL abandon the transaction and flush all FIFOs, with no response issued.

Structure
REQ-023 Package dmac_iochannel_mc_pkg SHALL hold the state enum and the RESP_OKAY/SLVERR/DECERR constants.
REQ-024 Sub-module dmac_iochannel_mc_fifo SHALL be instantiated 2*NUM_CH times via generate.

Verification
REQ-025 AW addr=0x2000 (ch2), awlen=3, 4 beats 0xA0..0xA3 with wlast on beat 4 -> coram_q[2] yields A0..A3, bresp=00.
REQ-026 User enqueues 3 words on ch1, AR addr=0x1000 arlen=2 -> 3 beats in order, rlast on beat 3 only, rresp=00.
REQ-027 AR arlen=3 with ch0 FIFO empty, refill one word per 5 cycles -> rvalid gaps, no duplicated or lost data.
REQ-028 Write 20 beats to ch3 (depth 16) while user is idle -> wready low after 16 beats; resumes after coram_deq.
REQ-029 awaddr=0x10000 awlen=1 -> 2 beats accepted, bresp=11, no FIFO changes; matching read returns rdata=0 and rresp=11.
REQ-030 wlast on beat 2 of awlen=3 -> bresp=10. Separately, ARESETN low during beat 2 -> bvalid never asserts and all FIFOs are empty.

Source files
------------

// File: rtl/dmac_iochannel_mc_pkg.sv
// Shared types and constants for the DMA I/O channel bridge.
package dmac_iochannel_mc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WDATA = 2'd1,
    WRESP = 2'd2,
    RDATA = 2'd3
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/dmac_iochannel_mc_fifo.sv
// Synchronous first-word-fall-through FIFO with registered occupancy flags.
module dmac_iochannel_mc_fifo #(
  parameter int W_D    = 32,
  parameter int ADDR_W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           enq,
  input  logic [W_D-1:0] d,
  input  logic           deq,
  output logic [W_D-1:0] q,
  output logic           empty,
  output logic           almost_empty,
  output logic           full,
  output logic           almost_full
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C    = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_M1_C = (ADDR_W + 1)'(DEPTH - 1);
  localparam logic [ADDR_W:0] CNT_ONE    = (ADDR_W + 1)'(1);

  logic [W_D-1:0]    mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              empty_q, almost_empty_q, full_q, almost_full_q;
  logic              enq_ok, deq_ok;

  // Accept enq only when not full and deq only when not empty; the other
  // side of a simultaneous pair still goes ahead on its own.
  always_comb begin
    enq_ok   = enq && !full_q;
    deq_ok   = deq && !empty_q;
    wr_ptr_d = enq_ok ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
    rd_ptr_d = deq_ok ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
    count_d  = count_q;
    if (enq_ok && !deq_ok)      count_d = count_q + CNT_ONE;
    else if (!enq_ok && deq_ok) count_d = count_q - CNT_ONE;
  end

  // Pointers, count and flags; flags are computed from the next count so they
  // line up with the count register on every edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
      full_q         <= 1'b0;
      almost_full_q  <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      empty_q        <= (count_d == '0);
      almost_empty_q <= (count_d <= CNT_ONE);
      full_q         <= (count_d == DEPTH_C);
      almost_full_q  <= (count_d >= DEPTH_M1_C);
    end
  end

  // Storage array; no reset so it maps onto memory primitives.
  always_ff @(posedge clk) begin
    if (enq_ok) mem[wr_ptr_q] <= d;
  end

  assign q            = mem[rd_ptr_q];
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;
  assign full         = full_q;
  assign almost_full  = almost_full_q;

endmodule

// File: rtl/dmac_iochannel_mc.sv
// Bus-to-user DMA I/O bridge: one outstanding burst steered into per-channel FIFOs.
module dmac_iochannel_mc
  import dmac_iochannel_mc_pkg::*;
#(
  parameter int W_D             = 32,
  parameter int W_EXT_A         = 32,
  parameter int W_BLEN          = 8,
  parameter int NUM_CH          = 4,
  parameter int W_CH            = $clog2(NUM_CH),
  parameter int CH_LSB          = 12,
  parameter int FIFO_ADDR_WIDTH = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  awvalid,
  input  logic [W_EXT_A-1:0]    awaddr,
  input  logic [W_BLEN-1:0]     awlen,
  output logic                  awready,
  input  logic                  wvalid,
  input  logic [W_D-1:0]        wdata,
  input  logic                  wlast,
  output logic                  wready,
  output logic                  bvalid,
  output logic [1:0]            bresp,
  input  logic                  bready,
  input  logic                  arvalid,
  input  logic [W_EXT_A-1:0]    araddr,
  input  logic [W_BLEN-1:0]     arlen,
  output logic                  arready,
  output logic                  rvalid,
  output logic [W_D-1:0]        rdata,
  output logic [1:0]            rresp,
  output logic                  rlast,
  input  logic                  rready,
  input  logic [NUM_CH-1:0]     coram_deq,
  output logic [NUM_CH*W_D-1:0] coram_q,
  output logic [NUM_CH-1:0]     coram_empty,
  output logic [NUM_CH-1:0]     coram_almost_empty,
  input  logic [NUM_CH-1:0]     coram_enq,
  input  logic [NUM_CH*W_D-1:0] coram_d,
  output logic [NUM_CH-1:0]     coram_full,
  output logic [NUM_CH-1:0]     coram_almost_full
);
  localparam logic [W_BLEN:0] BEAT_ONE = (W_BLEN + 1)'(1);

  logic [1:0]              rst_sync_q;
  logic                    rst_n;
  state_e                  state_q, state_d;
  logic [W_CH-1:0]         ch_q, ch_d;
  logic                    dec_q, dec_d;
  logic [W_BLEN:0]         remain_q, remain_d;
  logic                    werr_q, werr_d;
  logic                    awready_q, awready_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    aw_dec, ar_dec;
  logic                    aw_fire, ar_fire, w_fire, r_fire, b_fire;
  logic [NUM_CH-1:0]       wf_full, wf_almost_full, wf_enq;
  logic [NUM_CH-1:0]       rf_empty, rf_almost_empty, rf_deq;
  logic [NUM_CH-1:0][W_D-1:0] rf_q;
  logic                    unused_bits;

  // Reset asserts immediately and releases two clocks after ARESETN rises.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  assign aw_dec  = |awaddr[W_EXT_A-1:W_CH+CH_LSB];
  assign ar_dec  = |araddr[W_EXT_A-1:W_CH+CH_LSB];
  assign arready = awready_q && !awvalid;
  assign awready = awready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign wready  = (state_q == WDATA) && (dec_q || !wf_full[ch_q]);
  assign rvalid  = (state_q == RDATA) && (dec_q || !rf_empty[ch_q]);
  assign rdata   = ((state_q == RDATA) && !dec_q) ? rf_q[ch_q] : '0;
  assign rresp   = ((state_q == RDATA) && dec_q) ? RESP_DECERR : RESP_OKAY;
  assign rlast   = (state_q == RDATA) && (remain_q == BEAT_ONE);
  assign aw_fire = awvalid && awready_q;
  assign ar_fire = arvalid && arready;
  assign w_fire  = wvalid && wready;
  assign r_fire  = rvalid && rready;
  assign b_fire  = bvalid_q && bready;

  // Next-state logic: latch burst context on address handshakes, count beats.
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    dec_d    = dec_q;
    remain_d = remain_q;
    werr_d   = werr_q;
    bresp_d  = bresp_q;
    unique case (state_q)
      IDLE: begin
        if (aw_fire) begin
          ch_d     = awaddr[CH_LSB +: W_CH];
          dec_d    = aw_dec;
          remain_d = {1'b0, awlen} + BEAT_ONE;
          werr_d   = 1'b0;
          state_d  = WDATA;
        end else if (ar_fire) begin
          ch_d     = araddr[CH_LSB +: W_CH];
          dec_d    = ar_dec;
          remain_d = {1'b0, arlen} + BEAT_ONE;
          state_d  = RDATA;
        end
      end
      WDATA: begin
        if (w_fire) begin
          remain_d = remain_q - BEAT_ONE;
          if (wlast != (remain_q == BEAT_ONE)) werr_d = 1'b1;
          if (remain_q == BEAT_ONE) begin
            state_d = WRESP;
            bresp_d = dec_q ? RESP_DECERR : (werr_d ? RESP_SLVERR : RESP_OKAY);
          end
        end
      end
      WRESP: begin
        if (b_fire) begin
          state_d = IDLE;
          bresp_d = RESP_OKAY;
        end
      end
      RDATA: begin
        if (r_fire) begin
          remain_d = remain_q - BEAT_ONE;
          if (remain_q == BEAT_ONE) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    awready_d = (state_d == IDLE);
    bvalid_d  = (state_d == WRESP);
  end

  // State and registered handshake outputs.
  always_ff @(posedge ACLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ch_q      <= '0;
      dec_q     <= 1'b0;
      remain_q  <= '0;
      werr_q    <= 1'b0;
      awready_q <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      ch_q      <= ch_d;
      dec_q     <= dec_d;
      remain_q  <= remain_d;
      werr_q    <= werr_d;
      awready_q <= awready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
    end
  end

  // One write FIFO (bus->user) and one read FIFO (user->bus) per channel.
  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign wf_enq[gi] = w_fire && !dec_q && (ch_q == W_CH'(gi));
      assign rf_deq[gi] = r_fire && !dec_q && (ch_q == W_CH'(gi));

      dmac_iochannel_mc_fifo #(.W_D(W_D), .ADDR_W(FIFO_ADDR_WIDTH)) u_wfifo (
        .clk          (ACLK),
        .rst_n        (rst_n),
        .enq          (wf_enq[gi]),
        .d            (wdata),
        .deq          (coram_deq[gi]),
        .q            (coram_q[gi*W_D +: W_D]),
        .empty        (coram_empty[gi]),
        .almost_empty (coram_almost_empty[gi]),
        .full         (wf_full[gi]),
        .almost_full  (wf_almost_full[gi])
      );

      dmac_iochannel_mc_fifo #(.W_D(W_D), .ADDR_W(FIFO_ADDR_WIDTH)) u_rfifo (
        .clk          (ACLK),
        .rst_n        (rst_n),
        .enq          (coram_enq[gi]),
        .d            (coram_d[gi*W_D +: W_D]),
        .deq          (rf_deq[gi]),
        .q            (rf_q[gi]),
        .empty        (rf_empty[gi]),
        .almost_empty (rf_almost_empty[gi]),
        .full         (coram_full[gi]),
        .almost_full  (coram_almost_full[gi])
      );
    end
  endgenerate

  // Flags and in-page address bits that nothing downstream needs.
  assign unused_bits = &{1'b0, wf_almost_full, rf_almost_empty,
                         awaddr[CH_LSB-1:0], araddr[CH_LSB-1:0]};

endmodule
